// File: rtl/dfd_trace_sram_arb.sv
// Single-port trace SRAM arbiter: funnel writes win, a write-streak bound lets debug
// reads through, and read data returns on a fixed-latency valid pipeline.
module dfd_trace_sram_arb #(
  parameter int TRC_RAM_INDEX_WIDTH = 9,
  parameter int TRC_RAM_DATA_WIDTH  = 128,
  parameter int RD_LATENCY          = 1,
  parameter int MAX_WR_STREAK       = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           arb_en,
  input  logic                           wr_req_vld,
  output logic                           wr_req_rdy,
  input  logic [TRC_RAM_INDEX_WIDTH-1:0] wr_req_addr,
  input  logic                           wr_req_mask_en,
  input  logic [TRC_RAM_DATA_WIDTH-1:0]  wr_req_data,
  input  logic                           rd_req_vld,
  output logic                           rd_req_rdy,
  input  logic [TRC_RAM_INDEX_WIDTH-1:0] rd_req_addr,
  output logic                           rd_rsp_vld,
  output logic [TRC_RAM_DATA_WIDTH-1:0]  rd_rsp_data,
  output logic                           mem_chip_en,
  output logic                           mem_wr_en,
  output logic [TRC_RAM_INDEX_WIDTH-1:0] mem_wr_addr,
  output logic                           mem_wr_mask_en,
  output logic [TRC_RAM_DATA_WIDTH-1:0]  mem_wr_data,
  input  logic [TRC_RAM_DATA_WIDTH-1:0]  mem_rd_data,
  output logic                           arb_busy
);

  localparam int SW = $clog2(MAX_WR_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_WR_STREAK);

  logic [SW-1:0]                 r_streak;
  logic [RD_LATENCY:0]           r_rd_pipe;
  logic [TRC_RAM_DATA_WIDTH-1:0] r_rsp_data;
  logic                          w_force_rd;
  logic                          w_gnt_ok;
  logic                          w_wr_gnt;
  logic                          w_rd_gnt;

  // Grants are masked while reset is asserted so requesters never see a handshake then.
  assign w_gnt_ok   = arb_en & reset_n;
  assign w_force_rd = rd_req_vld & (r_streak == STREAK_MAX);
  assign w_rd_gnt   = w_gnt_ok & rd_req_vld & (~wr_req_vld | w_force_rd);
  assign w_wr_gnt   = w_gnt_ok & wr_req_vld & ~w_force_rd;
  assign wr_req_rdy = w_wr_gnt;
  assign rd_req_rdy = w_rd_gnt;

  // Response valid lines up with the SRAM output; data is held between responses.
  assign rd_rsp_vld  = r_rd_pipe[RD_LATENCY];
  assign rd_rsp_data = r_rd_pipe[RD_LATENCY] ? mem_rd_data : r_rsp_data;
  assign arb_busy    = wr_req_vld | rd_req_vld | (|r_rd_pipe);

  // Write-streak counter: only counts while a read is actually waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_streak <= {SW{1'b0}};
    end else if (w_wr_gnt && rd_req_vld) begin
      if (r_streak != STREAK_MAX) begin
        r_streak <= r_streak + SW'(1'b1);
      end else begin
        r_streak <= r_streak;
      end
    end else if (w_rd_gnt || !rd_req_vld) begin
      r_streak <= {SW{1'b0}};
    end else begin
      r_streak <= r_streak;
    end
  end

  // Issue stage toward the SRAM; write payload only changes on a write grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_chip_en    <= 1'b0;
      mem_wr_en      <= 1'b0;
      mem_wr_addr    <= {TRC_RAM_INDEX_WIDTH{1'b0}};
      mem_wr_mask_en <= 1'b0;
      mem_wr_data    <= {TRC_RAM_DATA_WIDTH{1'b0}};
    end else begin
      mem_chip_en <= w_wr_gnt | w_rd_gnt;
      mem_wr_en   <= w_wr_gnt;
      if (w_wr_gnt) begin
        mem_wr_addr    <= wr_req_addr;
        mem_wr_mask_en <= wr_req_mask_en;
        mem_wr_data    <= wr_req_data;
      end else if (w_rd_gnt) begin
        mem_wr_addr    <= rd_req_addr;
        mem_wr_mask_en <= mem_wr_mask_en;
        mem_wr_data    <= mem_wr_data;
      end else begin
        mem_wr_addr    <= mem_wr_addr;
        mem_wr_mask_en <= mem_wr_mask_en;
        mem_wr_data    <= mem_wr_data;
      end
    end
  end

  // Read valid shift register and response data hold register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_pipe  <= {(RD_LATENCY+1){1'b0}};
      r_rsp_data <= {TRC_RAM_DATA_WIDTH{1'b0}};
    end else begin
      r_rd_pipe <= {r_rd_pipe[RD_LATENCY-1:0], w_rd_gnt};
      if (r_rd_pipe[RD_LATENCY]) begin
        r_rsp_data <= mem_rd_data;
      end else begin
        r_rsp_data <= r_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_dfd_trace_sram_arb.sv
// Directed bench for dfd_trace_sram_arb with a behavioural 2-cycle SRAM model.
module tb_dfd_trace_sram_arb;
  localparam int IW = 9;
  localparam int DW = 128;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          arb_en;
  logic          wr_req_vld, wr_req_rdy, wr_req_mask_en;
  logic [IW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic          rd_req_vld, rd_req_rdy;
  logic [IW-1:0] rd_req_addr;
  logic          rd_rsp_vld;
  logic [DW-1:0] rd_rsp_data;
  logic          mem_chip_en, mem_wr_en, mem_wr_mask_en;
  logic [IW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;
  logic          arb_busy;

  int n_checks = 0;
  int n_fail   = 0;

  dfd_trace_sram_arb #(
    .TRC_RAM_INDEX_WIDTH(IW), .TRC_RAM_DATA_WIDTH(DW),
    .RD_LATENCY(LAT), .MAX_WR_STREAK(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .arb_en(arb_en),
    .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy), .wr_req_addr(wr_req_addr),
    .wr_req_mask_en(wr_req_mask_en), .wr_req_data(wr_req_data),
    .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy), .rd_req_addr(rd_req_addr),
    .rd_rsp_vld(rd_rsp_vld), .rd_rsp_data(rd_rsp_data),
    .mem_chip_en(mem_chip_en), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_mask_en(mem_wr_mask_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  // SRAM model: data appears LAT cycles after the cycle chip_en is high.
  logic [DW-1:0] sram [512];
  logic [DW-1:0] s0, s1;
  initial begin
    for (int i = 0; i < 512; i++) sram[i] = '0;
    s0 = '0;
    s1 = '0;
  end
  always @(posedge clk) begin
    if (mem_chip_en) begin
      if (mem_wr_en) sram[mem_wr_addr] <= mem_wr_data;
      else s0 <= sram[mem_wr_addr];
    end
    s1 <= s0;
  end
  assign mem_rd_data = s1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic wv, input logic [IW-1:0] wa,
                       input logic [DW-1:0] wd, input logic wm,
                       input logic rv, input logic [IW-1:0] ra);
    arb_en = a; wr_req_vld = wv; wr_req_addr = wa; wr_req_data = wd;
    wr_req_mask_en = wm; rd_req_vld = rv; rd_req_addr = ra;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic a; logic wv; logic [IW-1:0] wa; logic [DW-1:0] wd; logic wm;
    logic rv; logic [IW-1:0] ra;
    logic e_wr; logic e_rd; logic e_ce; logic e_we; logic [IW-1:0] e_addr;
    logic [DW-1:0] e_data; logic e_mask;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 9'd5, 128'hA5, 1'b1, 1'b0, 9'd0, 1'b1, 1'b0, 1'b1, 1'b1, 9'd5, 128'hA5, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 9'd0, 128'h0, 1'b0, 1'b1, 9'd9, 1'b0, 1'b1, 1'b1, 1'b0, 9'd9, 128'hA5, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 9'd0, 128'h0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd9, 128'hA5, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 9'd2, 128'h77, 1'b0, 1'b1, 9'd3, 1'b1, 1'b0, 1'b1, 1'b1, 9'd2, 128'h77, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 9'd2, 128'h77, 1'b0, 1'b1, 9'd3, 1'b0, 1'b0, 1'b0, 1'b0, 9'd2, 128'h77, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 9'd0, 128'h0, 1'b0, 1'b1, 9'd3, 1'b0, 1'b1, 1'b1, 1'b0, 9'd3, 128'h77, 1'b0};

    // Reset with every request asserted
    reset_n = 1'b0;
    drive(1'b1, 1'b1, 9'd1, 128'h1, 1'b1, 1'b1, 9'd2);
    #12;
    check("rst_wr_rdy", 128'(wr_req_rdy), 128'd0);
    check("rst_rd_rdy", 128'(rd_req_rdy), 128'd0);
    check("rst_ce", 128'(mem_chip_en), 128'd0);
    check("rst_we", 128'(mem_wr_en), 128'd0);
    check("rst_addr", 128'(mem_wr_addr), 128'd0);
    check("rst_mask", 128'(mem_wr_mask_en), 128'd0);
    check("rst_data", mem_wr_data, 128'd0);
    check("rst_rsp_vld", 128'(rd_rsp_vld), 128'd0);
    check("rst_rsp_data", rd_rsp_data, 128'd0);
    drive(1'b1, 1'b0, 9'd0, 128'h0, 1'b0, 1'b0, 9'd0);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();

    // Table of single-cycle grant vectors
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].a, vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].wm, vecs[i].rv, vecs[i].ra);
      @(negedge clk);
      check($sformatf("vec%0d_wr_rdy", i), 128'(wr_req_rdy), 128'(vecs[i].e_wr));
      check($sformatf("vec%0d_rd_rdy", i), 128'(rd_req_rdy), 128'(vecs[i].e_rd));
      next_cycle();
      check($sformatf("vec%0d_ce", i), 128'(mem_chip_en), 128'(vecs[i].e_ce));
      check($sformatf("vec%0d_we", i), 128'(mem_wr_en), 128'(vecs[i].e_we));
      check($sformatf("vec%0d_addr", i), 128'(mem_wr_addr), 128'(vecs[i].e_addr));
      check($sformatf("vec%0d_data", i), mem_wr_data, vecs[i].e_data);
      check($sformatf("vec%0d_mask", i), 128'(mem_wr_mask_en), 128'(vecs[i].e_mask));
    end

    // Starvation bound: eight writes then one read, repeating
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 9'(100 + i), 128'(i), 1'b0, 1'b1, 9'd1);
      @(negedge clk);
      check($sformatf("starve%0d_wr", i), 128'(wr_req_rdy), 128'((i % 9) != 8));
      check($sformatf("starve%0d_rd", i), 128'(rd_req_rdy), 128'((i % 9) == 8));
      next_cycle();
    end
    drive(1'b1, 1'b0, 9'd0, 128'h0, 1'b0, 1'b0, 9'd0);
    for (int i = 0; i < 5; i++) next_cycle();

    // Preload indices 3,4,5
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 9'(3 + i), 128'(30 + 10 * i), 1'b0, 1'b0, 9'd0);
      @(negedge clk);
      check($sformatf("pre%0d_wr", i), 128'(wr_req_rdy), 128'd1);
      next_cycle();
    end
    drive(1'b1, 1'b0, 9'd0, 128'h0, 1'b0, 1'b0, 9'd0);
    next_cycle();
    next_cycle();

    // Back-to-back reads return back-to-back three cycles after grant
    for (int k = 0; k < 8; k++) begin
      if (k < 3) drive(1'b1, 1'b0, 9'd0, 128'h0, 1'b0, 1'b1, 9'(3 + k));
      else drive(1'b1, 1'b0, 9'd0, 128'h0, 1'b0, 1'b0, 9'd0);
      @(negedge clk);
      if (k < 3) check($sformatf("lat%0d_rd_rdy", k), 128'(rd_req_rdy), 128'd1);
      check($sformatf("lat%0d_vld", k), 128'(rd_rsp_vld), 128'(k >= 3 && k <= 5));
      if (k >= 3 && k <= 5) check($sformatf("lat%0d_data", k), rd_rsp_data, 128'(30 + 10 * (k - 3)));
      if (k > 5) check($sformatf("lat%0d_hold", k), rd_rsp_data, 128'd50);
      next_cycle();
    end

    // Read-after-write to the same index
    for (int k = 0; k < 7; k++) begin
      if (k == 0) drive(1'b1, 1'b1, 9'd7, 128'h1234, 1'b0, 1'b0, 9'd0);
      else if (k == 1) drive(1'b1, 1'b0, 9'd0, 128'h0, 1'b0, 1'b1, 9'd7);
      else drive(1'b1, 1'b0, 9'd0, 128'h0, 1'b0, 1'b0, 9'd0);
      @(negedge clk);
      check($sformatf("raw%0d_vld", k), 128'(rd_rsp_vld), 128'(k == 4));
      if (k == 4) check("raw_data", rd_rsp_data, 128'h1234);
      next_cycle();
    end

    // arb_en low with a read in flight
    for (int k = 0; k < 7; k++) begin
      if (k == 0) drive(1'b1, 1'b0, 9'd0, 128'h0, 1'b0, 1'b1, 9'd3);
      else if (k < 6) drive(1'b0, 1'b1, 9'd8, 128'h88, 1'b0, 1'b1, 9'd4);
      else drive(1'b1, 1'b1, 9'd8, 128'h88, 1'b0, 1'b1, 9'd4);
      @(negedge clk);
      check($sformatf("dis%0d_wr", k), 128'(wr_req_rdy), 128'(k == 6));
      check($sformatf("dis%0d_rd", k), 128'(rd_req_rdy), 128'(k == 0));
      check($sformatf("dis%0d_busy", k), 128'(arb_busy), 128'd1);
      check($sformatf("dis%0d_vld", k), 128'(rd_rsp_vld), 128'(k == 3));
      if (k == 3) check("dis_data", rd_rsp_data, 128'd30);
      next_cycle();
    end
    drive(1'b1, 1'b0, 9'd0, 128'h0, 1'b0, 1'b0, 9'd0);
    for (int i = 0; i < 5; i++) next_cycle();

    // Reset pulse drops an outstanding read
    drive(1'b1, 1'b0, 9'd0, 128'h0, 1'b0, 1'b1, 9'd4);
    @(negedge clk);
    check("rstp_rd_rdy", 128'(rd_req_rdy), 128'd1);
    next_cycle();
    drive(1'b1, 1'b0, 9'd0, 128'h0, 1'b0, 1'b0, 9'd0);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rstp%0d_vld", k), 128'(rd_rsp_vld), 128'd0);
      if (k == 1) check("rstp_ce", 128'(mem_chip_en), 128'd0);
      next_cycle();
    end
    check("idle_busy", 128'(arb_busy), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
